// File: rtl/iiq_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : iiq_issue_scheduler
// Description : Issue scheduler and wakeup controller for the integer issue
//               queue (IIQ) shift queue. Writes source-ready bits back into
//               entries whose source tags match a wakeup broadcast, selects
//               the oldest fully-ready entry for dequeue, and blocks long ops
//               while the single long-latency unit is occupied.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_aL      : clock, asynchronous active-low reset
//   enq_fire         : queue accepted an enqueue this cycle
//   entry_douts      : queue contents, entry 0 is the oldest
//   wakeup_valid/tag : external wakeup broadcasts
//   fu_ready         : execute stage can accept an op
//   deq_ready        : to queue, mirrors fu_ready
//   deq_sel_onehot   : to queue, one-hot dequeue select (or all zeros)
//   wr_en / wr_data  : to queue, per-entry ready-bit write-back
//   issue_valid/long : an op issues this cycle / it is a long op
//   occupancy        : scheduler's copy of queue occupancy
//   long_busy        : long-latency unit busy
// Entry layout (LSB first): long, src1_rdy, src2_rdy, src1_tag, src2_tag,
//   dst_tag, payload.
// Build option: define IIQ_SCHED_SELF_WAKEUP_EN to broadcast the dst_tag of
//   issued ops internally (short: cycle after issue; long: cycle in which the
//   busy counter goes 1->0).
// ============================================================================
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif

module iiq_issue_scheduler #(
    parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
    parameter int TAG_WIDTH     = 6,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int N_WAKEUP      = 2,
    parameter int LONG_LAT      = 4,
    localparam int ENTRY_WIDTH  = 3 + 3*TAG_WIDTH + PAYLOAD_WIDTH,
    localparam int CTR_WIDTH    = $clog2(N_ENTRIES) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_aL,
    input  logic                                   enq_fire,
    input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  entry_douts,
    input  logic [N_WAKEUP-1:0]                    wakeup_valid,
    input  logic [N_WAKEUP-1:0][TAG_WIDTH-1:0]     wakeup_tag,
    input  logic                                   fu_ready,
    output logic                                   deq_ready,
    output logic [N_ENTRIES-1:0]                   deq_sel_onehot,
    output logic [N_ENTRIES-1:0]                   wr_en,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]  wr_data,
    output logic                                   issue_valid,
    output logic                                   issue_long,
    output logic [CTR_WIDTH-1:0]                   occupancy,
    output logic                                   long_busy
);

    localparam int c_BUSY_W = $clog2(LONG_LAT);
    localparam int c_IDX_W  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
    localparam int c_S1_LSB = 3;
    localparam int c_S2_LSB = 3 + TAG_WIDTH;
    localparam int c_DT_LSB = 3 + 2*TAG_WIDTH;
`ifdef IIQ_SCHED_SELF_WAKEUP_EN
    localparam int c_N_WK   = N_WAKEUP + 2;
`else
    localparam int c_N_WK   = N_WAKEUP;
`endif

    logic [CTR_WIDTH-1:0]                r_occ;
    logic [c_BUSY_W-1:0]                 r_busy_ctr;
    logic [c_N_WK-1:0]                   r_wkq_vld;
    logic [c_N_WK-1:0][TAG_WIDTH-1:0]    r_wkq_tag;

    logic [c_N_WK-1:0]                   w_wk_vld;
    logic [c_N_WK-1:0][TAG_WIDTH-1:0]    w_wk_tag;
    logic [N_ENTRIES-1:0]                w_valid;
    logic [N_ENTRIES-1:0]                w_m1;
    logic [N_ENTRIES-1:0]                w_m2;
    logic [N_ENTRIES-1:0]                w_elig;
    logic [N_ENTRIES-1:0]                w_sel;
    logic [c_IDX_W-1:0]                  w_sel_idx;
    logic                                w_found;
    logic                                w_issue_long;

`ifdef IIQ_SCHED_SELF_WAKEUP_EN
    logic                                r_self_vld;
    logic [TAG_WIDTH-1:0]                r_self_tag;
    logic [TAG_WIDTH-1:0]                r_long_tag;
`endif

    // Wakeup sources seen this cycle: external ports first, then the
    // internal short/long broadcasts when self-wakeup is built in.
    always_comb begin
        w_wk_vld = '0;
        w_wk_tag = '0;
        w_wk_vld[N_WAKEUP-1:0] = wakeup_valid;
        for (int k = 0; k < N_WAKEUP; k++) begin
            w_wk_tag[k] = wakeup_tag[k];
        end
`ifdef IIQ_SCHED_SELF_WAKEUP_EN
        w_wk_vld[N_WAKEUP]   = r_self_vld;
        w_wk_tag[N_WAKEUP]   = r_self_tag;
        w_wk_vld[N_WAKEUP+1] = (r_busy_ctr == c_BUSY_W'(1));
        w_wk_tag[N_WAKEUP+1] = r_long_tag;
`endif
    end

    // Source matching against current and previous-cycle wakeups. The
    // previous-cycle copy catches entries that were being enqueued (and so
    // not yet visible) when their producer broadcast.
    always_comb begin
        w_valid = '0;
        w_m1    = '0;
        w_m2    = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_valid[i] = (CTR_WIDTH'(i) < r_occ);
            for (int k = 0; k < c_N_WK; k++) begin
                if ((w_wk_vld[k] && w_wk_tag[k] == entry_douts[i][c_S1_LSB +: TAG_WIDTH]) ||
                    (r_wkq_vld[k] && r_wkq_tag[k] == entry_douts[i][c_S1_LSB +: TAG_WIDTH]))
                    w_m1[i] = 1'b1;
                if ((w_wk_vld[k] && w_wk_tag[k] == entry_douts[i][c_S2_LSB +: TAG_WIDTH]) ||
                    (r_wkq_vld[k] && r_wkq_tag[k] == entry_douts[i][c_S2_LSB +: TAG_WIDTH]))
                    w_m2[i] = 1'b1;
            end
            // Only sources that are not ready yet count as new matches.
            w_m1[i] = w_m1[i] & w_valid[i] & ~entry_douts[i][1];
            w_m2[i] = w_m2[i] & w_valid[i] & ~entry_douts[i][2];
        end
    end

    // Write-back and eligibility. Eligibility uses the stored ready bits,
    // so a woken entry becomes selectable the cycle after its write-back.
    always_comb begin
        wr_en   = '0;
        wr_data = entry_douts;
        w_elig  = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            wr_en[i] = w_m1[i] | w_m2[i];
            if (w_m1[i]) wr_data[i][1] = 1'b1;
            if (w_m2[i]) wr_data[i][2] = 1'b1;
            w_elig[i] = w_valid[i] & entry_douts[i][1] & entry_douts[i][2] &
                        (~entry_douts[i][0] | (r_busy_ctr == '0));
        end
    end

    // Oldest-first select: lowest index wins.
    always_comb begin
        w_sel     = '0;
        w_sel_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (fu_ready && w_elig[i] && !w_found) begin
                w_sel[i]  = 1'b1;
                w_sel_idx = c_IDX_W'(i);
                w_found   = 1'b1;
            end
        end
    end

    assign w_issue_long   = w_found & entry_douts[w_sel_idx][0];
    assign deq_ready      = fu_ready;
    assign deq_sel_onehot = w_sel;
    assign issue_valid    = w_found;
    assign issue_long     = w_issue_long;
    assign occupancy      = r_occ;
    assign long_busy      = (r_busy_ctr != '0);

    // Occupancy tracks the queue exactly; overflow/underflow is a protocol
    // violation by the producer and is deliberately not saturated.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_occ      <= '0;
            r_busy_ctr <= '0;
            r_wkq_vld  <= '0;
            r_wkq_tag  <= '0;
        end else begin
            r_occ <= r_occ + CTR_WIDTH'(enq_fire) - CTR_WIDTH'(w_found);
            if (w_issue_long)
                r_busy_ctr <= c_BUSY_W'(LONG_LAT - 1);
            else if (r_busy_ctr != '0)
                r_busy_ctr <= r_busy_ctr - c_BUSY_W'(1);
            r_wkq_vld <= w_wk_vld;
            r_wkq_tag <= w_wk_tag;
        end
    end

`ifdef IIQ_SCHED_SELF_WAKEUP_EN
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_self_vld <= 1'b0;
            r_self_tag <= '0;
            r_long_tag <= '0;
        end else begin
            r_self_vld <= w_found & ~w_issue_long;
            r_self_tag <= entry_douts[w_sel_idx][c_DT_LSB +: TAG_WIDTH];
            if (w_issue_long)
                r_long_tag <= entry_douts[w_sel_idx][c_DT_LSB +: TAG_WIDTH];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_iiq_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_iiq_issue_scheduler
// Description : Bench for iiq_issue_scheduler. A small shift-queue model
//               closes the loop (write-back, dequeue shift, tail enqueue);
//               per-cycle vectors carry stimulus and hand-derived expected
//               outputs through a scoreboard queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_iiq_issue_scheduler;

    localparam int N  = 4;
    localparam int TW = 6;
    localparam int PW = 32;
    localparam int NW = 2;
    localparam int LL = 4;
    localparam int EW = 3 + 3*TW + PW;
    localparam int CW = $clog2(N) + 1;

    logic                   clk = 1'b0;
    logic                   rst_aL = 1'b0;
    logic                   enq_fire = 1'b0;
    logic                   fu_ready = 1'b1;
    logic [EW-1:0]          enq_data = '0;
    logic [NW-1:0]          wk_valid = '0;
    logic [NW-1:0][TW-1:0]  wk_tag = '0;

    logic [N-1:0][EW-1:0]   q_mem, q_tmp, q_next;
    logic [CW-1:0]          q_cnt, q_cnt_next;
    int                     q_k, q_after;

    logic                   deq_ready;
    logic [N-1:0]           deq_sel_onehot;
    logic [N-1:0]           wr_en;
    logic [N-1:0][EW-1:0]   wr_data;
    logic                   issue_valid;
    logic                   issue_long;
    logic [CW-1:0]          occupancy;
    logic                   long_busy;

    int total = 0;
    int bad   = 0;

    iiq_issue_scheduler #(
        .N_ENTRIES(N), .TAG_WIDTH(TW), .PAYLOAD_WIDTH(PW),
        .N_WAKEUP(NW), .LONG_LAT(LL)
    ) dut (
        .clk(clk), .rst_aL(rst_aL), .enq_fire(enq_fire), .entry_douts(q_mem),
        .wakeup_valid(wk_valid), .wakeup_tag(wk_tag), .fu_ready(fu_ready),
        .deq_ready(deq_ready), .deq_sel_onehot(deq_sel_onehot), .wr_en(wr_en),
        .wr_data(wr_data), .issue_valid(issue_valid), .issue_long(issue_long),
        .occupancy(occupancy), .long_busy(long_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] mk(input logic lg, input logic r1, input logic r2,
                                         input int t1, input int t2, input int dst);
        logic [PW-1:0] pl;
        pl = 32'hA500_0000 | 32'(dst);
        return {pl, TW'(dst), TW'(t2), TW'(t1), r2, r1, lg};
    endfunction
    function automatic logic [EW-1:0] S(input int dst);  return mk(0, 1, 1, 0, 0, dst); endfunction
    function automatic logic [EW-1:0] L(input int dst);  return mk(1, 1, 1, 0, 0, dst); endfunction
    function automatic logic [EW-1:0] W1(input int t, input int dst); return mk(0, 0, 1, t, 0, dst); endfunction
    function automatic logic [EW-1:0] W2(input int t, input int dst); return mk(0, 1, 0, 0, t, dst); endfunction

    // Shift-queue model: write-back, then removal of the dequeued entry with
    // younger entries shifting down, then the new entry lands at the tail.
    always_comb begin
        q_tmp = q_mem;
        for (int i = 0; i < N; i++)
            if (wr_en[i]) q_tmp[i] = wr_data[i];
        q_next = q_tmp;
        q_k = N;
        for (int i = N - 1; i >= 0; i--)
            if (deq_sel_onehot[i]) q_k = i;
        for (int i = 0; i < N - 1; i++)
            if (q_k < N && i >= q_k) q_next[i] = q_tmp[i+1];
        q_after = int'(q_cnt) - ((q_k < N) ? 1 : 0);
        if (enq_fire && q_after >= 0 && q_after < N) q_next[q_after] = enq_data;
        q_cnt_next = CW'(q_after + (enq_fire ? 1 : 0));
    end

    always @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            q_cnt <= '0;
            for (int i = 0; i < N; i++) q_mem[i] <= mk(i % 2, 1, 1, i + 1, i + 2, 60 + i);
        end else begin
            q_mem <= q_next;
            q_cnt <= q_cnt_next;
        end
    end

    typedef struct {
        logic          enq;
        logic [EW-1:0] e;
        logic [NW-1:0] wv;
        logic [TW-1:0] t0, t1;
        logic          fu;
        logic [N-1:0]  sel, wr;
        logic          iv, il;
        logic [CW-1:0] occ;
        logic          busy;
    } vec_t;

    function automatic vec_t V(input logic enq, input logic [EW-1:0] e, input logic [NW-1:0] wv,
                               input int t0, input int t1, input logic fu,
                               input logic [N-1:0] sel, input logic [N-1:0] wr,
                               input logic iv, input logic il, input int occ, input logic busy);
        vec_t v;
        v.enq = enq; v.e = e; v.wv = wv; v.t0 = TW'(t0); v.t1 = TW'(t1); v.fu = fu;
        v.sel = sel; v.wr = wr; v.iv = iv; v.il = il; v.occ = CW'(occ); v.busy = busy;
        return v;
    endfunction

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t sb[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag, input int idx);
        vec_t e;
        @(negedge clk);
        enq_fire = v.enq; enq_data = v.e; wk_valid = v.wv;
        wk_tag[0] = v.t0; wk_tag[1] = v.t1; fu_ready = v.fu;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk($sformatf("%s%0d.sel", tag, idx), 64'(deq_sel_onehot), 64'(e.sel));
        chk($sformatf("%s%0d.wr_en", tag, idx), 64'(wr_en), 64'(e.wr));
        chk($sformatf("%s%0d.issue_valid", tag, idx), 64'(issue_valid), 64'(e.iv));
        chk($sformatf("%s%0d.issue_long", tag, idx), 64'(issue_long), 64'(e.il));
        chk($sformatf("%s%0d.occupancy", tag, idx), 64'(occupancy), 64'(e.occ));
        chk($sformatf("%s%0d.long_busy", tag, idx), 64'(long_busy), 64'(e.busy));
        chk($sformatf("%s%0d.deq_ready", tag, idx), 64'(deq_ready), 64'(e.fu));
    endtask

    task automatic idle_inputs();
        enq_fire = 1'b0; enq_data = '0; wk_valid = '0; wk_tag = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // ---- basic issue, wakeup, delayed wakeup, dual-source wakeup, long unit
        tbl_a.push_back(V(1, S(40),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_a.push_back(V(1, W1(20, 41),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_a.push_back(V(1, S(42),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 3, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0010, 4'b0000, 1, 0, 2, 0));
        tbl_a.push_back(V(0, '0,    2'b01, 20, 0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        tbl_a.push_back(V(1, W2(9, 43), 2'b01, 9, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        tbl_a.push_back(V(1, W1(30, 44),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_a.push_back(V(1, W1(5, 45),   0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,    2'b10, 0, 5, 1, 4'b0000, 4'b0010, 0, 0, 2, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0010, 4'b0000, 1, 0, 2, 0));
        tbl_a.push_back(V(0, '0,    2'b01, 30, 0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        tbl_a.push_back(V(1, mk(0, 0, 0, 7, 8, 46), 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_a.push_back(V(0, '0,    2'b01, 7, 0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,    2'b10, 0, 8, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        tbl_a.push_back(V(1, L(47),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_a.push_back(V(1, L(48),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_a.push_back(V(1, S(49),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 1, 3, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0010, 4'b0000, 1, 0, 2, 1));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 1));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 1));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 1, 1, 0));
        tbl_a.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 1));
        tbl_a.push_back(V(1, S(50),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 1));

        // ---- full queue, top-index select, multi-entry wakeup, self-wakeup
        tbl_b.push_back(V(1, W1(33, 51),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_b.push_back(V(1, W1(33, 52),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_b.push_back(V(1, W1(33, 53),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 0));
        tbl_b.push_back(V(1, S(54),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 3, 0));
        tbl_b.push_back(V(1, S(55),       0, 0, 0, 1, 4'b1000, 4'b0000, 1, 0, 4, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b1000, 4'b0000, 1, 0, 4, 0));
        tbl_b.push_back(V(0, '0,    2'b01, 33, 0, 1, 4'b0000, 4'b0111, 0, 0, 3, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 3, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 2, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
        tbl_b.push_back(V(1, S(12),       0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0));
        tbl_b.push_back(V(1, W1(12, 56),  0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 2, 0));
`ifdef IIQ_SCHED_SELF_WAKEUP_EN
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0001, 0, 0, 1, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0001, 4'b0000, 1, 0, 1, 0));
`else
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 0));
        tbl_b.push_back(V(0, '0,          0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 1, 0));
`endif

        // ---- reset state, with ready-looking queue contents and fu_ready=1
        idle_inputs();
        fu_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst.sel", 64'(deq_sel_onehot), 64'd0);
        chk("rst.wr_en", 64'(wr_en), 64'd0);
        chk("rst.occupancy", 64'(occupancy), 64'd0);
        chk("rst.long_busy", 64'(long_busy), 64'd0);
        chk("rst.issue_valid", 64'(issue_valid), 64'd0);
        chk("rst.issue_long", 64'(issue_long), 64'd0);
        chk("rst.deq_ready_hi", 64'(deq_ready), 64'd1);
        fu_ready = 1'b0;
        #1;
        chk("rst.deq_ready_lo", 64'(deq_ready), 64'd0);
        @(negedge clk);
        rst_aL = 1'b1;

        for (int i = 0; i < tbl_a.size(); i++) run_vec(tbl_a[i], "a", i);

        // ---- asynchronous reset in the middle of a busy period
        @(negedge clk);
        idle_inputs();
        fu_ready = 1'b0;
        #2;
        chk("midrst.pre_occ", 64'(occupancy), 64'd1);
        chk("midrst.pre_busy", 64'(long_busy), 64'd1);
        rst_aL = 1'b0;
        #1;
        chk("midrst.occ", 64'(occupancy), 64'd0);
        chk("midrst.busy", 64'(long_busy), 64'd0);
        chk("midrst.sel", 64'(deq_sel_onehot), 64'd0);
        @(negedge clk);
        rst_aL = 1'b1;

        for (int i = 0; i < tbl_b.size(); i++) run_vec(tbl_b[i], "b", i);

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
